wb_master_port: RTL and testbench

Single-transaction Wishbone classic master sitting directly upstream of `wb_slave_register` and its sibling slaves. It accepts one command at a time on a valid/ready interface and runs exactly one Wishbone cycle (`cyc_o`/`stb_o`) per command. On `ack_i`, it captures `dat_i` and returns it on a one-cycle response strobe. It guarantees at least one `stb_o`-low cycle between bus cycles, which the slave needs to leave its phase-end wait.

---
 rtl/wb_pkg.sv | 26 ++
 rtl/wb_master_port_if.sv | 64 ++++++
 rtl/wb_master_timer.sv | 34 +++
 rtl/wb_master_port.sv | 94 +++++++++
 tb/tb_wb_master_port.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types for the Wishbone classic master port.
// Bus widths come from the ADDR_WIDTH/DATA_WIDTH macros of parameters.sv.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package wb_pkg;

  typedef enum logic [1:0] {
    WBM_IDLE = 2'd0,
    WBM_BUS  = 2'd1,
    WBM_DONE = 2'd2
  } wbm_state_t;

  typedef struct packed {
    logic                   we;
    logic [`ADDR_WIDTH-1:0] adr;
    logic [`DATA_WIDTH-1:0] dat;
  } wbm_cmd_t;

  localparam int WB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/wb_master_port_if.sv
// Command/response handshake plus Wishbone bus signals of the master port.
// master: the port's view; slave: the command source and bus slave side.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface wb_master_port_if;

  logic                   cmd_valid_i;
  logic                   cmd_ready_o;
  logic                   cmd_we_i;
  logic [`ADDR_WIDTH-1:0] cmd_adr_i;
  logic [`DATA_WIDTH-1:0] cmd_dat_i;
  logic                   rsp_valid_o;
  logic [`DATA_WIDTH-1:0] rsp_dat_o;
  logic                   rsp_err_o;
  logic [`ADDR_WIDTH-1:0] adr_o;
  logic [`DATA_WIDTH-1:0] dat_o;
  logic                   we_o;
  logic                   cyc_o;
  logic                   stb_o;
  logic [`DATA_WIDTH-1:0] dat_i;
  logic                   ack_i;

  modport master (
    input  cmd_valid_i,
    output cmd_ready_o,
    input  cmd_we_i,
    input  cmd_adr_i,
    input  cmd_dat_i,
    output rsp_valid_o,
    output rsp_dat_o,
    output rsp_err_o,
    output adr_o,
    output dat_o,
    output we_o,
    output cyc_o,
    output stb_o,
    input  dat_i,
    input  ack_i
  );

  modport slave (
    output cmd_valid_i,
    input  cmd_ready_o,
    output cmd_we_i,
    output cmd_adr_i,
    output cmd_dat_i,
    input  rsp_valid_o,
    input  rsp_dat_o,
    input  rsp_err_o,
    input  adr_o,
    input  dat_o,
    input  we_o,
    input  cyc_o,
    input  stb_o,
    output dat_i,
    output ack_i
  );

endinterface

// File: rtl/wb_master_timer.sv
// Clearable saturating cycle counter for the bus-cycle timeout.
// expired marks the TIMEOUT_CYCLES-th enabled cycle since the last clear.
module wb_master_timer
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] MAX  = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && cnt_q != MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q counts finished cycles, so the current one is number cnt_q+1
  assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/wb_master_port.sv
// Single-transaction Wishbone classic master with valid/ready commands.
// Define WB_MASTER_TIMEOUT_EN to abandon bus cycles after TIMEOUT_CYCLES.
module wb_master_port
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  wb_master_port_if.master bus
);

  wbm_state_t             state_q;
  wbm_state_t             state_d;
  wbm_cmd_t               cmd_q;
  logic                   ready_q;
  logic                   accept;
  logic                   expired;
  logic                   bus_end;
  logic [`DATA_WIDTH-1:0] rsp_dat_q;

  assign accept  = bus.cmd_valid_i && ready_q;
  assign bus_end = (state_q == WBM_BUS) && (bus.ack_i || expired);

`ifdef WB_MASTER_TIMEOUT_EN
  wb_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (accept),
    .en     (state_q == WBM_BUS),
    .expired(expired)
  );

  logic rsp_err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_err_q <= 1'b0;
    end else if (bus_end) begin
      rsp_err_q <= !bus.ack_i;
    end
  end

  assign bus.rsp_err_o = rsp_err_q;
`else
  assign expired       = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WBM_IDLE: if (accept) state_d = WBM_BUS;
      WBM_BUS:  if (bus_end) state_d = WBM_DONE;
      WBM_DONE: state_d = WBM_IDLE;
      default:  state_d = WBM_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= WBM_IDLE;
      ready_q   <= 1'b0;
      cmd_q     <= '0;
      rsp_dat_q <= '0;
    end else begin
      state_q <= state_d;
      // registered so ready stays low through reset and rises one edge later
      ready_q <= (state_d == WBM_IDLE);
      if (accept) begin
        cmd_q <= '{
          we:  bus.cmd_we_i,
          adr: bus.cmd_adr_i,
          dat: bus.cmd_dat_i
        };
      end
      if (bus_end) begin
        rsp_dat_q <= bus.ack_i ? bus.dat_i : '0;
      end
    end
  end

  assign bus.cmd_ready_o = ready_q;
  assign bus.cyc_o       = (state_q == WBM_BUS);
  assign bus.stb_o       = (state_q == WBM_BUS);
  assign bus.rsp_valid_o = (state_q == WBM_DONE);
  assign bus.rsp_dat_o   = rsp_dat_q;
  assign bus.adr_o       = cmd_q.adr;
  assign bus.dat_o       = cmd_q.dat;
  assign bus.we_o        = cmd_q.we;

endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port against a behavioural register slave.
// The slave returns ~adr and acks on a selectable sampling edge (0 = never).
module tb_wb_master_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wb_master_port_if bus ();

  wb_master_port #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;
  int ack_edge = 3;
  int sl_cnt;
  logic sl_ack;

  // ack is raised one edge before the master's sampling edge E<ack_edge>
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_cnt <= 0;
      sl_ack <= 1'b0;
    end else if (!bus.stb_o) begin
      sl_cnt <= 0;
      sl_ack <= 1'b0;
    end else if (sl_ack) begin
      sl_ack <= 1'b0;
    end else begin
      sl_cnt <= sl_cnt + 1;
      sl_ack <= (ack_edge != 0) && (sl_cnt == ack_edge - 2);
    end
  end

  assign bus.ack_i = sl_ack;
  assign bus.dat_i = ~bus.adr_o;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic we,
                         input logic [7:0] adr, input logic [7:0] dat,
                         input logic [7:0] exp_dat, input logic exp_err,
                         input int exp_lat);
    int lat;
    logic hold_ok;
    lat = -1;
    hold_ok = 1'b1;
    @(negedge clk);
    check({tag, "/ready"}, 32'(bus.cmd_ready_o), 32'd1);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i = we;
    bus.cmd_adr_i = adr;
    bus.cmd_dat_i = dat;
    @(posedge clk);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) bus.cmd_valid_i = 1'b0;
      if (bus.rsp_valid_o) begin
        lat = i;
        break;
      end
      if (!(bus.cyc_o && bus.stb_o && !bus.cmd_ready_o &&
            bus.adr_o == adr && bus.dat_o == dat && bus.we_o == we))
        hold_ok = 1'b0;
    end
    check({tag, "/lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "/hold"}, 32'(hold_ok), 32'd1);
    check({tag, "/stb_done"}, 32'(bus.stb_o), 32'd0);
    check({tag, "/rdat"}, 32'(bus.rsp_dat_o), 32'(exp_dat));
    check({tag, "/rerr"}, 32'(bus.rsp_err_o), 32'(exp_err));
    @(negedge clk);
    check({tag, "/vld1"}, 32'(bus.rsp_valid_o), 32'd0);
    check({tag, "/rdat_hold"}, 32'(bus.rsp_dat_o), 32'(exp_dat));
  endtask

  task automatic pulse_reset(input string tag);
    int seen;
    seen = 0;
    rst_n = 1'b0;
    #1;
    check({tag, "/cyc"}, 32'(bus.cyc_o), 32'd0);
    check({tag, "/stb"}, 32'(bus.stb_o), 32'd0);
    check({tag, "/ready"}, 32'(bus.cmd_ready_o), 32'd0);
    check({tag, "/adr"}, 32'(bus.adr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o || bus.stb_o) seen++;
    end
    check({tag, "/no_rsp"}, 32'(seen), 32'd0);
    check({tag, "/ready_up"}, 32'(bus.cmd_ready_o), 32'd1);
  endtask

  initial begin
    int gap;
    int reacc;
    int nrsp;
    int stray;
    logic [7:0] r0;
    logic [7:0] r1;

    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i = 1'b0;
    bus.cmd_adr_i = 8'h00;
    bus.cmd_dat_i = 8'h00;

    #2;
    check("rst/ready", 32'(bus.cmd_ready_o), 32'd0);
    check("rst/cyc", 32'(bus.cyc_o), 32'd0);
    check("rst/stb", 32'(bus.stb_o), 32'd0);
    check("rst/vld", 32'(bus.rsp_valid_o), 32'd0);
    check("rst/adr", 32'(bus.adr_o), 32'd0);
    check("rst/rerr", 32'(bus.rsp_err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel/ready", 32'(bus.cmd_ready_o), 32'd1);

    run_cmd("rd05", 1'b0, 8'h05, 8'h00, 8'hFA, 1'b0, 3);

    run_cmd("wr00", 1'b1, 8'h00, 8'h3C, 8'hFF, 1'b0, 3);
    check("idle/adr", 32'(bus.adr_o), 32'h00);
    check("idle/dat", 32'(bus.dat_o), 32'h3C);
    check("idle/we", 32'(bus.we_o), 32'd1);

    gap = 0;
    reacc = -1;
    nrsp = 0;
    r0 = 8'h00;
    r1 = 8'h00;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i = 1'b0;
    bus.cmd_adr_i = 8'h01;
    bus.cmd_dat_i = 8'h00;
    @(posedge clk);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) bus.cmd_adr_i = 8'h02;
      if (bus.rsp_valid_o) begin
        if (nrsp == 0) r0 = bus.rsp_dat_o;
        else r1 = bus.rsp_dat_o;
        nrsp++;
      end
      if (reacc < 0) begin
        if (!bus.stb_o) gap++;
        else if (gap > 0) begin
          reacc = i;
          bus.cmd_valid_i = 1'b0;
        end
      end
    end
    check("b2b/reaccept", 32'(reacc), 32'd5);
    check("b2b/gap", 32'(gap), 32'd2);
    check("b2b/nrsp", 32'(nrsp), 32'd2);
    check("b2b/r0", 32'(r0), 32'hFE);
    check("b2b/r1", 32'(r1), 32'hFD);

    ack_edge = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    run_cmd("tmo", 1'b0, 8'h33, 8'h00, 8'h00, 1'b1, 4);
`else
    stray = 0;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_adr_i = 8'h33;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.cmd_valid_i = 1'b0;
      if (bus.rsp_valid_o || !bus.stb_o) stray++;
    end
    check("stall/waiting", 32'(stray), 32'd0);
    pulse_reset("stall_rst");
`endif

    ack_edge = 3;
    @(negedge clk);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i = 1'b0;
    bus.cmd_adr_i = 8'h20;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    @(negedge clk);
    check("rbus/stb_pre", 32'(bus.stb_o), 32'd1);
    pulse_reset("rbus");
    run_cmd("rd10", 1'b0, 8'h10, 8'h00, 8'hEF, 1'b0, 3);

    ack_edge = 4;
    run_cmd("coinc", 1'b0, 8'h5A, 8'h00, 8'hA5, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
